// File: rtl/data_memory.sv
// Data-memory stage: word-addressed RAM with memory-mapped board I/O.
// The RAM is decoded from the low 8 KB. HEX, LEDR and LEDG are write registers,
// and KEY and SW are read-only inputs. Reads are combinational and writes happen
// on the clock edge.
// Optional build macro: DMEM_IO_READBACK_EN. When it is defined, reads of
// HEX/LEDR/LEDG return the register value instead of 0.
module data_memory #(
  parameter int unsigned     DBITS        = 32,
  parameter int unsigned     DMEMADDRBITS = 13,
  parameter int unsigned     DMEMWORDBITS = 2,
  parameter int unsigned     DMEMWORDS    = 2048,
  parameter logic [DBITS-1:0] ADDR_HEX    = 32'hF000_0000,
  parameter logic [DBITS-1:0] ADDR_LEDR   = 32'hF000_0004,
  parameter logic [DBITS-1:0] ADDR_LEDG   = 32'hF000_0008,
  parameter logic [DBITS-1:0] ADDR_KEY    = 32'hF000_0010,
  parameter logic [DBITS-1:0] ADDR_SW     = 32'hF000_0014
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEn,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] dataIn,
  input  logic [9:0]       sw,
  input  logic [3:0]       key,
  output logic [9:0]       ledr,
  output logic [7:0]       ledg,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [DBITS-1:0] dataOut
);

  localparam int unsigned IdxBits = DMEMADDRBITS - DMEMWORDBITS;

  logic [DBITS-1:0] mem [DMEMWORDS];
  logic [15:0]      hex_q;
  logic [9:0]       ledr_q;
  logic [7:0]       ledg_q;

  logic               ram_sel;
  logic [IdxBits-1:0] ram_idx;
  logic               hex_sel, ledr_sel, ledg_sel, key_sel, sw_sel;
  logic               wr_ok;
  logic               unused_addr;

  // The byte-offset bits are ignored because every access is a whole word.
  assign unused_addr = ^addr[DMEMWORDBITS-1:0];

  assign ram_sel  = (addr[DBITS-1:DMEMADDRBITS] == '0);
  assign ram_idx  = addr[DMEMADDRBITS-1:DMEMWORDBITS];
  assign hex_sel  = (addr == ADDR_HEX);
  assign ledr_sel = (addr == ADDR_LEDR);
  assign ledg_sel = (addr == ADDR_LEDG);
  assign key_sel  = (addr == ADDR_KEY);
  assign sw_sel   = (addr == ADDR_SW);
  assign wr_ok    = wrEn && !reset;

  // RAM store. Reset does not clear the contents, and stores are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (wr_ok && ram_sel) begin
      mem[ram_idx] <= dataIn;
    end
  end

  // Output registers. Reset takes priority over a store in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q  <= '0;
      ledr_q <= '0;
      ledg_q <= '0;
    end else if (wrEn) begin
      if (hex_sel)  hex_q  <= dataIn[15:0];
      if (ledr_sel) ledr_q <= dataIn[9:0];
      if (ledg_sel) ledg_q <= dataIn[7:0];
    end
  end

  // Combinational read mux. Unmapped addresses read as 0.
  always_comb begin
    dataOut = '0;
    if (ram_sel) begin
      dataOut = mem[ram_idx];
    end else if (key_sel) begin
      dataOut = {{(DBITS-4){1'b0}}, key};
    end else if (sw_sel) begin
      dataOut = {{(DBITS-10){1'b0}}, sw};
`ifdef DMEM_IO_READBACK_EN
    end else if (hex_sel) begin
      dataOut = {{(DBITS-16){1'b0}}, hex_q};
    end else if (ledr_sel) begin
      dataOut = {{(DBITS-10){1'b0}}, ledr_q};
    end else if (ledg_sel) begin
      dataOut = {{(DBITS-8){1'b0}}, ledg_q};
`else
    end else begin
      dataOut = '0;
`endif
    end
  end

  // Seven-segment decode. The outputs are active-low with bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Drive the board outputs from the registers.
  always_comb begin
    ledr = ledr_q;
    ledg = ledg_q;
    hex0 = seg7(hex_q[3:0]);
    hex1 = seg7(hex_q[7:4]);
    hex2 = seg7(hex_q[11:8]);
    hex3 = seg7(hex_q[15:12]);
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory.
// Stimulus pushes expected observations into a queue and raises chk.
// A monitor pops the queue and compares on the falling edge.
module tb_data_memory;

  localparam logic [31:0] AHex  = 32'hF000_0000;
  localparam logic [31:0] ALedr = 32'hF000_0004;
  localparam logic [31:0] ALedg = 32'hF000_0008;
  localparam logic [31:0] AKey  = 32'hF000_0010;
  localparam logic [31:0] ASw   = 32'hF000_0014;

  localparam int SelData = 0;
  localparam int SelLedr = 1;
  localparam int SelLedg = 2;
  localparam int SelHex  = 3;

  logic        clk = 1'b0;
  logic        reset, wrEn;
  logic [31:0] addr, dataIn, dataOut;
  logic [9:0]  sw, ledr;
  logic [3:0]  key;
  logic [7:0]  ledg;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        chk = 1'b0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  data_memory dut (
    .clk     (clk),
    .reset   (reset),
    .wrEn    (wrEn),
    .addr    (addr),
    .dataIn  (dataIn),
    .sw      (sw),
    .key     (key),
    .ledr    (ledr),
    .ledg    (ledg),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  // Monitor: compares everything queued while chk marks the outputs as valid.
  always @(negedge clk) begin
    if (chk) begin
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] obs;
        e = q.pop_front();
        case (e.sel)
          SelData: obs = dataOut;
          SelLedr: obs = {22'b0, ledr};
          SelLedg: obs = {24'b0, ledg};
          default: obs = {4'b0, hex3, hex2, hex1, hex0};
        endcase
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, obs, e.exp);
        end
      end
    end
  end

  task automatic expect_out(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    q.push_back(e);
    chk = 1'b1;
    @(negedge clk);
    #1 chk = 1'b0;
  endtask

  task automatic expect_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a;
    expect_out(SelData, exp, name);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    wrEn = 1'b1;
    addr = a;
    dataIn = d;
    @(posedge clk);
    #1 wrEn = 1'b0;
  endtask

  function automatic logic [31:0] hexv(input logic [6:0] h3, input logic [6:0] h2,
                                       input logic [6:0] h1, input logic [6:0] h0);
    return {4'b0, h3, h2, h1, h0};
  endfunction

  initial begin
    reset = 1'b1; wrEn = 1'b0; addr = '0; dataIn = '0; sw = '0; key = '0;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    expect_out(SelLedr, 32'h0, "rst_ledr");
    expect_out(SelLedg, 32'h0, "rst_ledg");
    expect_out(SelHex, hexv(7'h40, 7'h40, 7'h40, 7'h40), "rst_hex");

    // Basic RAM store and load.
    do_write(32'h400, 32'h37);
    do_write(32'h404, 32'hE1);
    expect_read(32'h404, 32'hE1, "ram_404");
    expect_read(32'h400, 32'h37, "ram_400");

    // Byte-offset bits are ignored, and the top word of the RAM window is usable.
    do_write(32'h403, 32'hDEAD_BEEF);
    expect_read(32'h400, 32'hDEAD_BEEF, "ram_offset");
    do_write(32'h1FFC, 32'hA5A5_0001);
    expect_read(32'h1FFC, 32'hA5A5_0001, "ram_top");
    expect_read(32'h1FFF, 32'hA5A5_0001, "ram_top_off");
    do_write(32'h400, 32'h37);

    // An unmapped store must not alias RAM word 0.
    do_write(32'h0, 32'h77);
    do_write(32'h2000, 32'h99);
    expect_read(32'h0, 32'h77, "no_alias");

    // Read and write the same address in one cycle: the old value shows until the edge.
    do_write(32'h408, 32'h11);
    wrEn = 1'b1; addr = 32'h408; dataIn = 32'h22;
    expect_out(SelData, 32'h11, "rw_old");
    @(posedge clk);
    #1 wrEn = 1'b0;
    expect_read(32'h408, 32'h22, "rw_new");

    // HEX and LED registers.
    do_write(AHex, 32'h1234);
    expect_out(SelHex, hexv(7'h79, 7'h24, 7'h30, 7'h19), "hex_1234");
    do_write(AHex, 32'hFFFF_BCEF);
    expect_out(SelHex, hexv(7'h03, 7'h46, 7'h06, 7'h0E), "hex_bcef");
    do_write(AHex, 32'h90AD);
    expect_out(SelHex, hexv(7'h10, 7'h40, 7'h08, 7'h21), "hex_90ad");
    do_write(AHex, 32'h5678);
    expect_out(SelHex, hexv(7'h12, 7'h02, 7'h78, 7'h00), "hex_5678");
    do_write(ALedr, 32'h3FF);
    expect_out(SelLedr, 32'h3FF, "ledr_3ff");
    do_write(ALedg, 32'h1C3);
    expect_out(SelLedg, 32'hC3, "ledg_c3");

    // Board inputs. Stores to the read-only addresses are dropped.
    sw = 10'h2A5; key = 4'hE;
    expect_read(ASw, 32'h2A5, "sw_read");
    expect_read(AKey, 32'hE, "key_read");
    do_write(ASw, 32'h111);
    expect_read(ASw, 32'h2A5, "sw_ro");
    expect_out(SelLedr, 32'h3FF, "sw_wr_ledr");
    expect_out(SelLedg, 32'hC3, "sw_wr_ledg");

    // Reset wins over a simultaneous store and leaves the RAM contents intact.
    reset = 1'b1;
    do_write(ALedg, 32'hFF);
    reset = 1'b0;
    expect_out(SelLedg, 32'h0, "rst_wr_ledg");
    expect_out(SelLedr, 32'h0, "rst2_ledr");
    expect_out(SelHex, hexv(7'h40, 7'h40, 7'h40, 7'h40), "rst2_hex");
    expect_read(32'h400, 32'h37, "ram_keep");

    // Unmapped reads return 0; the LED and HEX registers read back only with the readback macro.
    expect_read(32'h2000, 32'h0, "unmapped_2000");
    expect_read(32'hF000_000C, 32'h0, "unmapped_c");
    do_write(ALedr, 32'h155);
    do_write(AHex, 32'hBEEF);
`ifdef DMEM_IO_READBACK_EN
    expect_read(ALedr, 32'h155, "ledr_rb");
    expect_read(AHex, 32'hBEEF, "hex_rb");
`else
    expect_read(ALedr, 32'h0, "ledr_rb");
    expect_read(AHex, 32'h0, "hex_rb");
`endif
    expect_out(SelLedr, 32'h155, "ledr_155");

    // Wait a bounded time for the monitor to drain the queue.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
